// File: rtl/fixed_point_recip_inv_pkg.sv
// Shared state encodings, default widths and counter sizing for the
// fixed-point reciprocal inverter.
package fixed_point_recip_inv_pkg;

  localparam int unsigned DEF_IN_W   = 64;
  localparam int unsigned DEF_FRAC_W = 32;
  localparam int unsigned DEF_OUT_W  = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DIV   = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Wide enough for the longest iteration count (FRAC_W+2 steps).
  function automatic int unsigned cnt_width(input int unsigned frac_w);
    return $clog2(frac_w + 2);
  endfunction

endpackage

// File: rtl/fixed_point_recip_inv_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// subtract the divisor when it fits.
module recip_div_step #(
  parameter int unsigned W = 64
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] q,
  input  logic         din,
  output logic [W:0]   rem_next,
  output logic         qbit
);

  logic [W+1:0] shifted;

  always_comb begin
    shifted  = {rem, din};
    qbit     = (shifted >= {2'b00, q});
    rem_next = qbit ? (W+1)'(shifted - {2'b00, q}) : (W+1)'(shifted);
  end

endmodule

// File: rtl/fixed_point_recip_inv.sv
// Sequential inverse of a fixed-point reciprocal: a = 2^FRAC_W / q.
// Build option RECIP_INV_ROUND_EN selects round-half-up instead of truncation.
module fixed_point_recip_inv
  import fixed_point_recip_inv_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned FRAC_W = DEF_FRAC_W,
  parameter int unsigned OUT_W  = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] a,
  output logic             div_by_zero,
  output logic             overflow
);

`ifdef RECIP_INV_ROUND_EN
  localparam int unsigned N = FRAC_W + 2;
`else
  localparam int unsigned N = FRAC_W + 1;
`endif
  localparam int unsigned CNT_W = cnt_width(FRAC_W);
  localparam int unsigned QW    = N;
  localparam int unsigned RW    = (QW + 1 > OUT_W) ? QW + 1 : OUT_W;

  logic [1:0]       state;
  logic [IN_W-1:0]  q_r;
  logic [IN_W:0]    rem;
  logic [IN_W:0]    rem_next;
  logic [QW-1:0]    quo;
  logic [CNT_W-1:0] cnt;
  logic             din;
  logic             qbit;
  logic [QW:0]      r_full;
  logic [OUT_W-1:0] sat_max;
  logic             r_ovf;

  // The dividend is a single 1 followed by zeros, so its current bit is
  // simply "first iteration" rather than a stored shift register.
  assign din = (cnt == CNT_W'(N - 1));

  recip_div_step #(.W(IN_W)) u_step (
    .rem      (rem),
    .q        (q_r),
    .din      (din),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_comb begin
    sat_max = '1;
    r_full  = {1'b0, quo};
`ifdef RECIP_INV_ROUND_EN
    r_full  = (r_full + (QW+1)'(1)) >> 1;
`endif
    r_ovf   = (RW'(r_full) > RW'(sat_max));
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      q_r         <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      a           <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            q_r <= q;
            rem <= '0;
            quo <= '0;
            if (q == '0) begin
              a           <= '1;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              state       <= ST_DONE;
            end else begin
              cnt   <= CNT_W'(N - 1);
              state <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          rem <= rem_next;
          quo <= {quo[QW-2:0], qbit};
          if (cnt == '0) begin
            state <= ST_ROUND;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_ROUND: begin
          a           <= r_ovf ? '1 : OUT_W'(r_full);
          overflow    <= r_ovf;
          div_by_zero <= 1'b0;
          state       <= ST_DONE;
        end
        default: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_recip_inv.sv
// Directed-vector bench for fixed_point_recip_inv; expectations follow the
// RECIP_INV_ROUND_EN build setting.
module tb_fixed_point_recip_inv;

`ifdef RECIP_INV_ROUND_EN
  localparam int N_DIV = 34;
  localparam logic [31:0] EXP_Q2 = 32'd1;
  localparam logic [31:0] EXP_Q04 = 32'd3;
`else
  localparam int N_DIV = 33;
  localparam logic [31:0] EXP_Q2 = 32'd0;
  localparam logic [31:0] EXP_Q04 = 32'd2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] q;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a;
  logic        div_by_zero;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fixed_point_recip_inv dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .q           (q),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .a           (a),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [63:0] qv, input logic [31:0] ea,
                        input logic edz, input logic eov, input int elat);
    int lat;
    @(negedge clk);
    check({tag, " in_ready"}, 64'(in_ready), 64'(1));
    q        = qv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    q        = 64'h0123_4567_89AB_CDEF;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " a"}, 64'(a), 64'(ea));
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
    check({tag, " overflow"}, 64'(overflow), 64'(eov));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 64'(out_valid), 64'(0));
    check({tag, " in_ready back"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    q         = '0;
    #1;
    check("reset in_ready", 64'(in_ready), 64'(1));
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset a", 64'(a), 64'(0));
    check("reset div_by_zero", 64'(div_by_zero), 64'(0));
    check("reset overflow", 64'(overflow), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("q=1.0",    64'h0000_0001_0000_0000, 32'd1,  1'b0, 1'b0, N_DIV + 2);
    run_op("q=1/3",    64'h0000_0000_5555_5555, 32'd3,  1'b0, 1'b0, N_DIV + 2);
    run_op("q=1/10",   64'h0000_0000_1999_9999, 32'd10, 1'b0, 1'b0, N_DIV + 2);
    run_op("q=1/4",    64'h0000_0000_4000_0000, 32'd4,  1'b0, 1'b0, N_DIV + 2);
    run_op("q=2.0",    64'h0000_0002_0000_0000, EXP_Q2, 1'b0, 1'b0, N_DIV + 2);
    run_op("q=0.4",    64'h0000_0000_6666_6666, EXP_Q04, 1'b0, 1'b0, N_DIV + 2);
    run_op("q>2",      64'h0000_0002_0000_0001, 32'd0,  1'b0, 1'b0, N_DIV + 2);
    run_op("q=3.0",    64'h0000_0003_0000_0000, 32'd0,  1'b0, 1'b0, N_DIV + 2);
    run_op("q=max",    64'hFFFF_FFFF_FFFF_FFFF, 32'd0,  1'b0, 1'b0, N_DIV + 2);
    run_op("q=0",      64'h0,                   32'hFFFF_FFFF, 1'b1, 1'b0, 1);
    run_op("q=1lsb",   64'h1,                   32'hFFFF_FFFF, 1'b0, 1'b1, N_DIV + 2);
    run_op("q=2lsb",   64'h2,                   32'h8000_0000, 1'b0, 1'b0, N_DIV + 2);

    // Back-pressure: result must hold while out_ready stays low.
    @(negedge clk);
    q        = 64'h0000_0000_4000_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("stall latency", 64'(lat), 64'(N_DIV + 2));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      q        = 64'h0000_0000_1000_0000 + 64'(i);
      @(posedge clk);
      #1;
      check("stall a", 64'(a), 64'(4));
      check("stall flags", 64'({div_by_zero, overflow}), 64'(0));
      check("stall out_valid", 64'(out_valid), 64'(1));
      check("stall in_ready", 64'(in_ready), 64'(0));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release out_valid", 64'(out_valid), 64'(0));
    check("release in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    check("no stray op", 64'(in_ready), 64'(1));

    // Reset in the middle of a division.
    @(negedge clk);
    q        = 64'h0000_0001_0000_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset in_ready", 64'(in_ready), 64'(1));
    check("midreset out_valid", 64'(out_valid), 64'(0));
    check("midreset a", 64'(a), 64'(0));
    check("midreset flags", 64'({div_by_zero, overflow}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    run_op("post-reset q=1/4", 64'h0000_0000_4000_0000, 32'd4, 1'b0, 1'b0, N_DIV + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fixed_point_recip_inv.md
Name: fixed_point_recip_inv

Overview:
- Sequential inverse of fixed_point_recip: takes an unsigned fixed-point reciprocal value (Q32.32 by default) and recovers the integer it represents, a = 2^FRAC_W / q.
- Sits downstream of the reciprocal unit. Used to convert stored reciprocal scale factors back to integer periods and counts.
- Implemented as a radix-2 restoring divider with a valid/ready handshake on both input and output.

Parameters:
- IN_W, 64, width of fixed-point input q.
- FRAC_W, 32, number of fractional bits in q.
- OUT_W, 32, width of integer result.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  q is valid.
- in_ready  output  1  block can accept q; high only in IDLE.
- q  input  IN_W  unsigned fixed-point reciprocal value.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- a  output  OUT_W  integer result.
- div_by_zero  output  1  q was 0; qualified by out_valid.
- overflow  output  1  result saturated; qualified by out_valid.

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, a=0, div_by_zero=0, overflow=0; internal remainder and quotient registers cleared.
- Reset mid-operation aborts any division; no result is produced for the aborted input.
- States: IDLE, DIV, ROUND, DONE.
- IDLE: if in_valid && in_ready at cycle T, latch q and clear remainder and quotient.
  - q==0: go directly to DONE. At T+1: a=all-ones, div_by_zero=1, overflow=0.
  - q!=0: go to DIV with iteration counter = N-1.
- DIV: computes Qx = floor(2^(FRAC_W+1)/q), one quotient bit per cycle, MSB first.
  - Dividend is 1 followed by FRAC_W+1 zeros, N = FRAC_W+2 bits wide.
  - Each step: rem' = {rem, dividend bit}. If rem' >= q, subtract q and shift in 1; else shift in 0.
  - Remainder register is IN_W+1 bits.
  - Counter decrements each cycle; on 0, go to ROUND.
  - DIV occupies cycles T+1..T+N.
- ROUND (cycle T+N+1): r = (Qx+1)>>1, which is round-half-up.
  - If r > 2^OUT_W-1: a=all-ones, overflow=1. Else a=r[OUT_W-1:0], overflow=0.
  - Go to DONE.
- DONE: out_valid=1 from T+N+2 (or T+1 for q==0).
  - a and the flags are held stable while out_ready=0.
  - On out_ready: out_valid=0 next cycle, go to IDLE.
  - in_ready rises in the cycle after acceptance; no overlap of consecutive operations.
- in_valid while busy is ignored; q is not re-sampled.
- q values above 2^(FRAC_W+1) give a=0 with no flags.
- Minimum throughput: one result per N+3 cycles.

Optional Feature:
- Macro: RECIP_INV_ROUND_EN.
- Defined: behaviour as above (N = FRAC_W+2 with round-half-up step).
- Undefined: truncation, a = floor(2^FRAC_W/q).
  - N = FRAC_W+1 DIV cycles.
  - ROUND only saturates, performing no increment.
  - out_valid from T+N+2 with this smaller N.

Decomposition:
- Shared include/package: state encodings (IDLE=2'd0, DIV=2'd1, ROUND=2'd2, DONE=2'd3) and default width localparams (IN_W, FRAC_W, OUT_W).
- The counter width derivation $clog2(FRAC_W+2) also belongs there.
- One natural combinational sub-module, recip_div_step: inputs rem, q, next dividend bit; outputs rem_next and qbit.

Test Plan:
- Values below assume RECIP_INV_ROUND_EN defined unless stated.
- q=0x0000_0001_0000_0000 (1.0) -> a=1, flags 0, out_valid at T+36.
- q=0x0000_0000_5555_5555 -> a=3. q=0x0000_0000_1999_9999 -> a=10. q=0x0000_0000_4000_0000 -> a=4.
- q=0x0000_0002_0000_0000 (2.0) -> a=1 with RECIP_INV_ROUND_EN; a=0 without it, with out_valid at T+35.
- q=0 -> a=0xFFFF_FFFF, div_by_zero=1 at T+1. q=1 -> a=0xFFFF_FFFF, overflow=1.
- out_ready held low 10 cycles -> a and flags stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> out_valid falls next cycle and in_ready rises.
- Reset asserted at T+10 of a division -> outputs immediately at reset values. A following q=0x0000_0000_4000_0000 -> a=4 with correct latency.
